// File: rtl/rf_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 16x32 register file (R15 = PC).
// Register-file controls are decoded from the registered state and IR.
module rf_sequencer #(
  parameter int DMEM_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             IMEM_ready,
  input  logic [31:0]      IMEM_data,
  input  logic             DMEM_ack,
  output logic             IMEM_req,
  output logic             DMEM_req,
  output logic             DMEM_we,
  output logic [3:0]       IR_ARn,
  output logic [3:0]       IR_ARs,
  output logic [3:0]       IR_ARm,
  output logic [3:0]       mux_ARd_or_15,
  output logic             CNTRL_write_en_ARd,
  output logic             CNTRL_sel_DMEM,
  output logic             CNTRL_PC_inc,
  output logic             halted,
  output logic             err_timeout,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_ALU  = 4'b0000;
  localparam logic [3:0] OP_LDR  = 4'b0001;
  localparam logic [3:0] OP_STR  = 4'b0010;
  localparam logic [3:0] OP_B    = 4'b0011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int WAIT_W = $clog2(DMEM_TIMEOUT + 1);

  logic [2:0]        state, state_next;
  logic [31:0]       ir;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;
  logic [3:0]        opcode, ard;
  logic              is_nop, wr_r15, timeout_hit, retire;

  assign opcode = ir[31:28];
  assign ard    = ir[15:12];
  assign is_nop = !(opcode inside {OP_ALU, OP_LDR, OP_STR, OP_B, OP_HALT});
  assign wr_r15 = (opcode == OP_B) || (ard == 4'd15);
  assign timeout_hit = !DMEM_ack && (wait_cnt == WAIT_W'(DMEM_TIMEOUT - 1));

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (IMEM_ready) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_ALU || opcode == OP_B)       state_next = S_WB;
        else if (opcode == OP_LDR || opcode == OP_STR) state_next = S_MEM;
        else if (opcode == OP_HALT)                    state_next = S_HALT;
        else                                           state_next = S_FETCH;
      end
      S_MEM: begin
        if (DMEM_ack)         state_next = (opcode == OP_LDR) ? S_WB : S_FETCH;
        else if (timeout_hit) state_next = S_HALT;
      end
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // STR retires in the ack cycle, so this is the only enable that looks at an input.
  always_comb begin
    CNTRL_PC_inc = 1'b0;
    retire       = 1'b0;
    case (state)
      S_EXEC: begin
        CNTRL_PC_inc = is_nop;
        retire       = is_nop;
      end
      S_MEM: begin
        CNTRL_PC_inc = DMEM_ack && (opcode == OP_STR);
        retire       = DMEM_ack && (opcode == OP_STR);
      end
      S_WB: begin
        CNTRL_PC_inc = !wr_r15;
        retire       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state         <= S_FETCH;
      ir            <= '0;
      wait_cnt      <= '0;
      err_q         <= 1'b0;
      instr_retired <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && IMEM_ready) ir <= IMEM_data;
      if (state == S_MEM && !DMEM_ack && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
      else                                             wait_cnt <= '0;
      if (state == S_MEM && timeout_hit) err_q <= 1'b1;
      if (retire) instr_retired <= instr_retired + 1'b1;
    end
  end

  // Requests are gated by RESET so they drop without waiting for a clock edge.
  assign IMEM_req           = (state == S_FETCH) && !RESET;
  assign DMEM_req           = (state == S_MEM) && !RESET;
  assign DMEM_we            = DMEM_req && (opcode == OP_STR);
  assign IR_ARn             = ir[19:16];
  assign IR_ARs             = ir[11:8];
  assign IR_ARm             = ir[3:0];
  assign mux_ARd_or_15      = (state == S_WB && opcode == OP_B) ? 4'd15 : ard;
  assign CNTRL_write_en_ARd = (state == S_WB);
  assign CNTRL_sel_DMEM     = (state == S_WB) && (opcode == OP_LDR);
  assign halted             = (state == S_HALT);
  assign err_timeout        = err_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed bench for rf_sequencer: per-instruction vector table plus hand-written
// halt, timeout, mid-access reset and counter-wrap sequences.
module tb_rf_sequencer;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic        IMEM_ready;
  logic [31:0] IMEM_data;
  logic        DMEM_ack;
  logic        IMEM_req, DMEM_req, DMEM_we;
  logic [3:0]  IR_ARn, IR_ARs, IR_ARm, mux_ARd_or_15;
  logic        CNTRL_write_en_ARd, CNTRL_sel_DMEM, CNTRL_PC_inc;
  logic        halted, err_timeout;
  logic [3:0]  instr_retired;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  rf_sequencer #(.DMEM_TIMEOUT(16), .CNT_W(4)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .IMEM_ready(IMEM_ready), .IMEM_data(IMEM_data),
    .DMEM_ack(DMEM_ack), .IMEM_req(IMEM_req), .DMEM_req(DMEM_req), .DMEM_we(DMEM_we),
    .IR_ARn(IR_ARn), .IR_ARs(IR_ARs), .IR_ARm(IR_ARm), .mux_ARd_or_15(mux_ARd_or_15),
    .CNTRL_write_en_ARd(CNTRL_write_en_ARd), .CNTRL_sel_DMEM(CNTRL_sel_DMEM),
    .CNTRL_PC_inc(CNTRL_PC_inc), .halted(halted), .err_timeout(err_timeout),
    .instr_retired(instr_retired)
  );

  typedef struct {
    logic [31:0] instr;
    int ack_wait;   // DMEM wait cycles before ack, -1 = never
    int cycles, we, addr, pcinc, pcwe, sel, req, dwe, ret, halt;
  } vec_t;

  // Observations gathered by run()
  int o_cyc, o_we, o_addr, o_pcinc, o_pcwe, o_sel, o_req, o_dwe, o_ret, o_dec;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1; IMEM_ready = 1'b0; IMEM_data = '0; DMEM_ack = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b0;
    #1;
  endtask

  // Issues one instruction from FETCH and observes every cycle until the next FETCH or HALT.
  task automatic run(input logic [31:0] instr, input int ack_wait);
    logic [31:0] ir;
    logic [3:0]  start_ret, d;
    int          w;
    ir = instr;
    o_cyc = 0; o_we = 0; o_addr = 0; o_pcinc = 0; o_pcwe = 0;
    o_sel = 0; o_req = 0; o_dwe = 0; o_ret = 0; o_dec = 0;
    @(negedge CLOCK_50);
    w = 0;
    while (!IMEM_req && w < 10) begin @(negedge CLOCK_50); w++; end
    start_ret  = instr_retired;
    IMEM_ready = 1'b1; IMEM_data = instr;
    @(negedge CLOCK_50);
    IMEM_ready = 1'b0; IMEM_data = '0;
    #1;
    o_cyc = 1;
    o_dec = (IR_ARn == ir[19:16] && IR_ARs == ir[11:8] && IR_ARm == ir[3:0]) ? 1 : 0;
    while (!IMEM_req && !halted && o_cyc < 40) begin
      if (DMEM_req && ack_wait >= 0 && o_req == ack_wait) DMEM_ack = 1'b1;
      #1;
      if (CNTRL_write_en_ARd) begin
        o_we++; o_addr = int'(mux_ARd_or_15); o_sel = int'(CNTRL_sel_DMEM);
        if (CNTRL_PC_inc) o_pcwe++;
      end
      if (CNTRL_PC_inc) o_pcinc++;
      if (DMEM_req) begin o_req++; if (DMEM_we) o_dwe = 1; end
      @(negedge CLOCK_50);
      DMEM_ack = 1'b0;
      #1;
      o_cyc++;
    end
    d = instr_retired - start_ret;
    o_ret = int'(d);
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, "_cycles"}, o_cyc, v.cycles);
    chk({tag, "_decode_addr"}, o_dec, 1);
    chk({tag, "_we_cycles"}, o_we, v.we);
    if (v.we != 0) begin
      chk({tag, "_wr_addr"}, o_addr, v.addr);
      chk({tag, "_sel_dmem"}, o_sel, v.sel);
    end
    chk({tag, "_pcinc_cycles"}, o_pcinc, v.pcinc);
    chk({tag, "_pcinc_with_we"}, o_pcwe, v.pcwe);
    chk({tag, "_dmem_req_cycles"}, o_req, v.req);
    if (v.req != 0) chk({tag, "_dmem_we"}, o_dwe, v.dwe);
    chk({tag, "_retired"}, o_ret, v.ret);
    chk({tag, "_halted"}, int'(halted), v.halt);
  endtask

  vec_t vecs[8];

  initial begin
    //            instr         ack  cyc we addr pci pcwe sel req dwe ret halt
    vecs[0] = '{32'h0003_7205,  -1,  4, 1,  7,  1,  1,  0,  0,  0,  1,  0}; // ALU Rd=7
    vecs[1] = '{32'h3001_4000,  -1,  4, 1, 15,  0,  0,  0,  0,  0,  1,  0}; // B
    vecs[2] = '{32'h0002_F103,  -1,  4, 1, 15,  0,  0,  0,  0,  0,  1,  0}; // ALU Rd=15
    vecs[3] = '{32'h1005_6000,   3,  8, 1,  6,  1,  1,  1,  4,  0,  1,  0}; // LDR 3 waits
    vecs[4] = '{32'h2004_9000,   0,  4, 0,  0,  1,  0,  0,  1,  1,  1,  0}; // STR no wait
    vecs[5] = '{32'h2004_9000,   2,  6, 0,  0,  1,  0,  0,  3,  1,  1,  0}; // STR 2 waits
    vecs[6] = '{32'h5001_2345,  -1,  3, 0,  0,  1,  0,  0,  0,  0,  1,  0}; // opcode 0101
    vecs[7] = '{32'h1000_F000,   0,  5, 1, 15,  0,  0,  1,  1,  0,  1,  0}; // LDR Rd=15

    RESET = 1'b1; IMEM_ready = 1'b0; IMEM_data = '0; DMEM_ack = 1'b0;
    #12;
    chk("rst_imem_req", int'(IMEM_req), 0);
    chk("rst_dmem_req", int'(DMEM_req), 0);
    chk("rst_write_en", int'(CNTRL_write_en_ARd), 0);
    chk("rst_pc_inc", int'(CNTRL_PC_inc), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_retired", int'(instr_retired), 0);
    do_reset();
    chk("post_rst_imem_req", int'(IMEM_req), 1);

    for (int i = 0; i < 8; i++) begin
      run(vecs[i].instr, vecs[i].ack_wait);
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end
    chk("retired_after_table", int'(instr_retired), 8);

    // Eight more NOPs take the 4-bit count through 15 and wrap to 0.
    for (int i = 0; i < 7; i++) run(32'h5000_0000, -1);
    chk("retired_15", int'(instr_retired), 15);
    run(32'hA000_0000, -1);
    chk("retired_wrap", int'(instr_retired), 0);

    // HALT opcode: sticky, no retire, no timeout flag.
    run(32'hF000_0000, -1);
    chk("halt_cycles", o_cyc, 3);
    chk("halt_halted", int'(halted), 1);
    chk("halt_retired", o_ret, 0);
    chk("halt_err", int'(err_timeout), 0);
    IMEM_ready = 1'b1; IMEM_data = 32'h0003_7205;
    repeat (3) @(negedge CLOCK_50);
    #1;
    IMEM_ready = 1'b0;
    chk("halt_sticky", int'(halted), 1);
    chk("halt_imem_req", int'(IMEM_req), 0);
    chk("halt_write_en", int'(CNTRL_write_en_ARd), 0);
    chk("halt_pc_inc", int'(CNTRL_PC_inc), 0);

    // DMEM never acks: 16 MEM cycles then error halt.
    do_reset();
    chk("rst_clears_halt", int'(halted), 0);
    run(32'h1005_6000, -1);
    chk("tmo_cycles", o_cyc, 19);
    chk("tmo_req_cycles", o_req, 16);
    chk("tmo_halted", int'(halted), 1);
    chk("tmo_err", int'(err_timeout), 1);
    chk("tmo_dmem_req", int'(DMEM_req), 0);
    chk("tmo_retired", o_ret, 0);
    repeat (5) @(negedge CLOCK_50);
    #1;
    chk("tmo_sticky", int'(halted), 1);
    chk("tmo_err_sticky", int'(err_timeout), 1);

    // Reset mid-MEM: DMEM_req drops asynchronously and the wait counter restarts.
    do_reset();
    chk("rst_clears_err", int'(err_timeout), 0);
    @(negedge CLOCK_50);
    IMEM_ready = 1'b1; IMEM_data = 32'h1003_2000;
    @(negedge CLOCK_50);
    IMEM_ready = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    #1;
    chk("mid_mem_req_on", int'(DMEM_req), 1);
    @(negedge CLOCK_50);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_dmem_req", int'(DMEM_req), 0);
    chk("mid_rst_imem_req", int'(IMEM_req), 0);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    #1;
    chk("mid_rst_fetch", int'(IMEM_req), 1);
    chk("mid_rst_retired", int'(instr_retired), 0);
    run(32'h1003_2000, 14);
    chk("cnt_cleared_cycles", o_cyc, 19);
    chk("cnt_cleared_halted", int'(halted), 0);
    chk("cnt_cleared_we", o_we, 1);
    chk("cnt_cleared_retired", int'(instr_retired), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
